// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - parameterised Mealy serial-sequence detector with loadable pattern.
// Optional saturating match counter is built when SEQDET_COUNT_EN is defined.
module seq_detect_param #(
  parameter int           N       = 4,
  parameter logic [N-1:0] PATTERN = 4'b1101,
  parameter int           CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
  input  logic             valid,
  input  logic             overlap,
  input  logic             load,
  input  logic [N-1:0]     pat_in,
  input  logic             clr_count,
  output logic             z,
  output logic [CNT_W-1:0] match_count
);

  localparam int             FW       = $clog2(N);
  localparam logic [FW-1:0]  FILL_MAX = FW'(N - 1);

  logic [N-1:0]  pat, pat_d;
  logic [N-2:0]  hist, hist_d;
  logic [FW-1:0] fill, fill_d;
  logic [N-1:0]  window;
  logic          accept;
  logic          match;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pat  <= PATTERN;
      hist <= '0;
      fill <= '0;
    end else begin
      pat  <= pat_d;
      hist <= hist_d;
      fill <= fill_d;
    end
  end

  // Full history is kept, so overlapping mode needs no failure function.
  always_comb begin
    pat_d  = pat;
    hist_d = hist;
    fill_d = fill;
    window = {hist, x};
    accept = valid & ~load;
    match  = accept & (fill == FILL_MAX) & (window == pat);
    if (load) begin
      pat_d  = pat_in;
      fill_d = '0;
    end else if (accept) begin
      if (match && !overlap) begin
        fill_d = '0;
      end else begin
        hist_d = window[N-2:0];
        fill_d = (fill == FILL_MAX) ? fill : fill + 1'b1;
      end
    end
  end

  assign z = match & ~reset;

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr_count) begin
      cnt <= '0;
    end else if (match && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign match_count = cnt;
`else
  logic unused_clr_count;

  assign unused_clr_count = clr_count;
  assign match_count      = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// tb/tb_seq_detect_param.sv - table-driven directed bench for seq_detect_param.
module tb_seq_detect_param;

`ifdef SEQDET_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       x = 1'b0;
  logic       valid = 1'b0;
  logic       overlap = 1'b0;
  logic       load = 1'b0;
  logic [3:0] pat_in = 4'b0000;
  logic       clr_count = 1'b0;
  logic       z;
  logic [1:0] match_count;

  int tests = 0;
  int fails = 0;
  int exp_cnt = 0;

  typedef struct {
    logic       v;
    logic       x;
    logic       ld;
    logic [3:0] pat;
    logic       ov;
    logic       clr;
    logic       ez;
    int         scen;
  } vec_t;

  vec_t vecs[$];

  seq_detect_param #(.N(4), .PATTERN(4'b1101), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .x(x), .valid(valid), .overlap(overlap),
    .load(load), .pat_in(pat_in), .clr_count(clr_count),
    .z(z), .match_count(match_count)
  );

  always #5 clk = ~clk;

  task automatic add(input logic v, input logic xx, input logic ld, input logic [3:0] p,
                     input logic ov, input logic clr, input logic ez, input int scen);
    vec_t e;
    e.v = v; e.x = xx; e.ld = ld; e.pat = p; e.ov = ov; e.clr = clr; e.ez = ez; e.scen = scen;
    vecs.push_back(e);
  endtask

  task automatic check_count(input int scen, input int idx);
    int want;
    want = CNT_EN ? exp_cnt : 0;
    tests++;
    if (match_count !== 2'(want)) begin
      fails++;
      $display("FAIL count scen%0d step%0d: match_count=%0d expected %0d", scen, idx, match_count, want);
    end
  endtask

  // Called just after a rising edge; checks z mid-cycle and the counter after the edge.
  task automatic step(input logic v, input logic xx, input logic ld, input logic [3:0] p,
                      input logic ov, input logic clr, input logic ez, input int scen, input int idx);
    valid = v; x = xx; load = ld; pat_in = p; overlap = ov; clr_count = clr;
    #4;
    tests++;
    if (z !== ez) begin
      fails++;
      $display("FAIL z scen%0d step%0d: z=%0b expected %0b", scen, idx, z, ez);
    end
    @(posedge clk);
    #1;
    if (clr) exp_cnt = 0;
    else if (ez && exp_cnt < 3) exp_cnt++;
    check_count(scen, idx);
  endtask

  initial begin
    logic [3:0] bits;

    // Scenario 1: overlapping, 1101101
    add(1,1,0,4'h0,1,0,0,1); add(1,1,0,4'h0,1,0,0,1); add(1,0,0,4'h0,1,0,0,1); add(1,1,0,4'h0,1,0,1,1);
    add(1,1,0,4'h0,1,0,0,1); add(1,0,0,4'h0,1,0,0,1); add(1,1,0,4'h0,1,0,1,1);
    // Scenario 2: non-overlapping, then 1,1,0,1 extra
    add(0,0,1,4'b1101,0,1,0,2);
    add(1,1,0,4'h0,0,0,0,2); add(1,1,0,4'h0,0,0,0,2); add(1,0,0,4'h0,0,0,0,2); add(1,1,0,4'h0,0,0,1,2);
    add(1,1,0,4'h0,0,0,0,2); add(1,0,0,4'h0,0,0,0,2); add(1,1,0,4'h0,0,0,0,2);
    add(1,1,0,4'h0,0,0,0,2); add(1,1,0,4'h0,0,0,0,2); add(1,0,0,4'h0,0,0,0,2); add(1,1,0,4'h0,0,0,1,2);
    // Scenario 4: load 0110 with valid=1 after 1,1,0
    add(0,0,1,4'b1101,0,1,0,4);
    add(1,1,0,4'h0,0,0,0,4); add(1,1,0,4'h0,0,0,0,4); add(1,0,0,4'h0,0,0,0,4);
    add(1,1,1,4'b0110,0,0,0,4);
    add(1,0,0,4'h0,0,0,0,4); add(1,1,0,4'h0,0,0,0,4); add(1,1,0,4'h0,0,0,0,4); add(1,0,0,4'h0,0,0,1,4);
    add(1,1,0,4'h0,0,0,0,4); add(1,1,0,4'h0,0,0,0,4); add(1,0,0,4'h0,0,0,0,4); add(1,1,0,4'h0,0,0,0,4);
    // Scenario 5: five overlapping matches saturate a 2-bit counter, then clear beats a match
    add(0,0,1,4'b1101,1,1,0,5);
    add(1,1,0,4'h0,1,0,0,5); add(1,1,0,4'h0,1,0,0,5); add(1,0,0,4'h0,1,0,0,5); add(1,1,0,4'h0,1,0,1,5);
    for (int k = 0; k < 4; k++) begin
      add(1,1,0,4'h0,1,0,0,5); add(1,0,0,4'h0,1,0,0,5); add(1,1,0,4'h0,1,0,1,5);
    end
    add(1,1,0,4'h0,1,0,0,5); add(1,0,0,4'h0,1,0,0,5); add(1,1,0,4'h0,1,1,1,5);

    // Reset state, with a would-be sample presented during reset
    valid = 1'b1; x = 1'b1;
    #12;
    tests++;
    if (z !== 1'b0) begin fails++; $display("FAIL reset_z: z=%0b expected 0", z); end
    check_count(0, 0);
    valid = 1'b0; x = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i])
      step(vecs[i].v, vecs[i].x, vecs[i].ld, vecs[i].pat, vecs[i].ov, vecs[i].clr, vecs[i].ez, vecs[i].scen, i);

    // Scenario 3: two gap cycles with random x before each valid bit
    step(0,0,1,4'b1101,1,0,0,3,0);
    bits = 4'b1101;
    for (int b = 3; b >= 0; b--) begin
      for (int g = 0; g < 2; g++)
        step(0,1'($urandom),0,4'h0,1,0,0,3,10 + 2*b + g);
      step(1,bits[b],0,4'h0,1,0,(b == 0),3,b);
    end

    // Scenario 6: asynchronous reset mid-sequence reverts the loaded pattern
    step(0,0,1,4'b0110,1,0,0,6,0);
    step(1,1,0,4'h0,1,0,0,6,1); step(1,1,0,4'h0,1,0,0,6,2); step(1,0,0,4'h0,1,0,0,6,3);
    valid = 1'b1; x = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    exp_cnt = 0;
    tests++;
    if (z !== 1'b0) begin fails++; $display("FAIL async_reset_z: z=%0b expected 0", z); end
    check_count(6, 4);
    #1;
    reset = 1'b0;
    valid = 1'b0;
    @(posedge clk);
    #1;
    step(1,1,0,4'h0,1,0,0,6,5);
    step(1,1,0,4'h0,1,0,0,6,6); step(1,0,0,4'h0,1,0,0,6,7); step(1,1,0,4'h0,1,0,1,6,8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
